// File: rtl/blink_led_pkg.sv
// Register map and bit positions shared by the blinking-LED Avalon-MM peripheral.
// The optional interrupt is built only when BLINK_LED_IRQ_EN is defined.
package blink_led_pkg;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_PERIOD0 = 2'd1;
    localparam logic [1:0] ADDR_PERIOD1 = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    // CTRL holds two channel enables plus the interrupt enable.
    localparam int CTRL_W          = 3;
    localparam int CTRL_EN_LSB     = 0;
    localparam int CTRL_IRQ_EN_BIT = 2;

    localparam int STATUS_LED_LSB  = 0;
    localparam int STATUS_PEND_BIT = 2;
    localparam int STATUS_TCNT_LSB = 16;
    localparam int STATUS_TCNT_W   = 16;

endpackage

// File: rtl/blink_led_channel.sv
// One blinking channel: half-period counter, terminal compare and LED toggle flop.
// A period write restarts the count and takes priority over a coincident terminal count.
module blink_led_channel #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [CNT_W-1:0] period,
    input  logic             period_wr,
    output logic             led,
    output logic             toggle_pulse
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_led;
    logic [CNT_W-1:0] w_term;
    logic             w_tc;

    // Periods of 0 and 1 both mean "toggle every clock".
    assign w_term       = (period == '0) ? '0 : period - CNT_W'(1);
    assign w_tc         = (r_cnt == w_term);
    assign toggle_pulse = en && !period_wr && w_tc;
    assign led          = r_led;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_led <= 1'b0;
        end else if (!en) begin
            r_cnt <= '0;
            r_led <= 1'b0;
        end else if (period_wr) begin
            r_cnt <= '0;
        end else if (w_tc) begin
            r_cnt <= '0;
            r_led <= ~r_led;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/avalon_blink_led.sv
// Avalon-MM slave driving two independently timed blinking LEDs.
// Define BLINK_LED_IRQ_EN to build the LED0-rise interrupt (CTRL[2], STATUS[2]).
module avalon_blink_led
    import blink_led_pkg::*;
#(
    parameter int          CNT_W        = 32,
    parameter int unsigned DEF_HALF_PER = 25000000,
    parameter int          TCNT_W       = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic [1:0]  led_out,
    output logic        irq
);

`ifdef BLINK_LED_IRQ_EN
    localparam logic [CTRL_W-1:0] CTRL_WR_MASK = 3'b111;
`else
    localparam logic [CTRL_W-1:0] CTRL_WR_MASK = 3'b011;
`endif

    logic [CTRL_W-1:0] r_ctrl;
    logic [CNT_W-1:0]  r_period0;
    logic [CNT_W-1:0]  r_period1;
    logic [TCNT_W-1:0] r_tcnt;
    logic [31:0]       r_readdata;

    logic              w_wr_ctrl;
    logic              w_wr_per0;
    logic              w_wr_per1;
    logic              w_led0;
    logic              w_led1;
    logic              w_toggle0;
    logic              w_toggle1_unused;
    logic              w_pending;
    logic [31:0]       w_rdata;

    assign w_wr_ctrl = avs_write && (avs_address == ADDR_CTRL);
    assign w_wr_per0 = avs_write && (avs_address == ADDR_PERIOD0);
    assign w_wr_per1 = avs_write && (avs_address == ADDR_PERIOD1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl    <= '0;
            r_period0 <= CNT_W'(DEF_HALF_PER);
            r_period1 <= CNT_W'(DEF_HALF_PER);
        end else begin
            if (w_wr_ctrl) r_ctrl    <= avs_writedata[CTRL_W-1:0] & CTRL_WR_MASK;
            if (w_wr_per0) r_period0 <= avs_writedata[CNT_W-1:0];
            if (w_wr_per1) r_period1 <= avs_writedata[CNT_W-1:0];
        end
    end

    blink_led_channel #(.CNT_W(CNT_W)) u_ch0 (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (r_ctrl[CTRL_EN_LSB]),
        .period       (r_period0),
        .period_wr    (w_wr_per0),
        .led          (w_led0),
        .toggle_pulse (w_toggle0)
    );

    blink_led_channel #(.CNT_W(CNT_W)) u_ch1 (
        .clk          (clk),
        .reset_n      (reset_n),
        .en           (r_ctrl[CTRL_EN_LSB+1]),
        .period       (r_period1),
        .period_wr    (w_wr_per1),
        .led          (w_led1),
        .toggle_pulse (w_toggle1_unused)
    );

    assign led_out = {w_led1, w_led0};

    // Counts only terminal-count toggles of LED0; a disable forcing it low is not a toggle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tcnt <= '0;
        end else if (w_toggle0) begin
            r_tcnt <= r_tcnt + TCNT_W'(1);
        end
    end

`ifdef BLINK_LED_IRQ_EN
    logic r_pending;
    logic w_wr_status;
    logic w_led0_rise;

    assign w_wr_status = avs_write && (avs_address == ADDR_STATUS);
    assign w_led0_rise = w_toggle0 && !w_led0;

    // A rise in the same cycle as a W1C keeps the flag set so no event is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= 1'b0;
        end else if (w_led0_rise) begin
            r_pending <= 1'b1;
        end else if (w_wr_status && avs_writedata[STATUS_PEND_BIT]) begin
            r_pending <= 1'b0;
        end
    end

    assign w_pending = r_pending;
    assign irq       = r_pending & r_ctrl[CTRL_IRQ_EN_BIT];
`else
    assign w_pending = 1'b0;
    assign irq       = 1'b0;
`endif

    // NOTE: default every combinational output first so no path infers a latch.
    always_comb begin
        w_rdata = '0;
        case (avs_address)
            ADDR_CTRL:    w_rdata[CTRL_W-1:0] = r_ctrl;
            ADDR_PERIOD0: w_rdata = 32'(r_period0);
            ADDR_PERIOD1: w_rdata = 32'(r_period1);
            ADDR_STATUS: begin
                w_rdata[STATUS_LED_LSB +: 2]              = {w_led1, w_led0};
                w_rdata[STATUS_PEND_BIT]                  = w_pending;
                w_rdata[STATUS_TCNT_LSB +: STATUS_TCNT_W] = STATUS_TCNT_W'(r_tcnt);
            end
            default:      w_rdata = '0;
        endcase
    end

    // Sampled from pre-edge state, so a same-cycle write is not visible yet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else if (avs_read) begin
            r_readdata <= w_rdata;
        end
    end

    assign avs_readdata = r_readdata;

endmodule

// File: tb/tb_avalon_blink_led.sv
// Randomized scoreboard bench for avalon_blink_led with a time-based reference model.
// Define BLINK_LED_IRQ_EN for both DUT and bench to exercise the interrupt build.
module tb_avalon_blink_led;

    localparam logic [31:0] DEF_HALF_PER = 32'd25000000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic [1:0]  led_out;
    logic        irq;

    int checks = 0;
    int errors = 0;

    avalon_blink_led dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .led_out       (led_out),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each channel toggles whenever a whole number of effective
    // half-periods has elapsed since its last restart (enable or period write).
    logic [2:0]  m_ctrl;
    logic [31:0] m_per [2];
    longint      m_anchor [2];
    logic [1:0]  m_led;
    logic [15:0] m_tcnt;
    logic        m_pend;
    logic        exp_irq;
    longint      t;
    logic [31:0] rd_q [$];

    function automatic longint peff(input logic [31:0] p);
        if (p == 32'd0) return 1;
        return longint'(p);
    endfunction

    function automatic logic [31:0] read_view(input logic [1:0] a);
        case (a)
            2'd0:    return {29'd0, m_ctrl};
            2'd1:    return m_per[0];
            2'd2:    return m_per[1];
            default: return {m_tcnt, 13'd0, m_pend, m_led};
        endcase
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            m_ctrl   = '0;
            m_per[0] = DEF_HALF_PER;
            m_per[1] = DEF_HALF_PER;
            m_anchor[0] = 0;
            m_anchor[1] = 0;
            m_led    = '0;
            m_tcnt   = '0;
            m_pend   = 1'b0;
            exp_irq  = 1'b0;
            t        = 0;
            rd_q.delete();
        end else begin
            logic rise;
            if (avs_read) rd_q.push_back(read_view(avs_address));
            rise = 1'b0;
            for (int n = 0; n < 2; n++) begin
                if (!m_ctrl[n]) begin
                    m_led[n]    = 1'b0;
                    m_anchor[n] = t;
                end else if (avs_write && avs_address == 2'(n + 1)) begin
                    m_anchor[n] = t;
                end else if ((t - m_anchor[n]) % peff(m_per[n]) == 0) begin
                    if (n == 0) begin
                        m_tcnt = m_tcnt + 16'd1;
                        if (!m_led[0]) rise = 1'b1;
                    end
                    m_led[n] = !m_led[n];
                end
            end
`ifdef BLINK_LED_IRQ_EN
            if (rise) m_pend = 1'b1;
            else if (avs_write && avs_address == 2'd3 && avs_writedata[2]) m_pend = 1'b0;
`endif
            if (avs_write) begin
                case (avs_address)
`ifdef BLINK_LED_IRQ_EN
                    2'd0: m_ctrl = avs_writedata[2:0];
`else
                    2'd0: m_ctrl = {1'b0, avs_writedata[1:0]};
`endif
                    2'd1: m_per[0] = avs_writedata;
                    2'd2: m_per[1] = avs_writedata;
                    default: ;
                endcase
            end
            exp_irq = m_pend & m_ctrl[2];
            t = t + 1;
        end
    end

    // Monitor: a read issued at one edge is presented at the next; otherwise data holds.
    logic [31:0] rd_hold = '0;
    always @(negedge clk) begin
        if (!reset_n) begin
            rd_hold = '0;
        end else begin
            if (rd_q.size() > 0) rd_hold = rd_q.pop_front();
            check("readdata", avs_readdata, rd_hold);
            check("led_out", 32'(led_out), 32'(m_led));
            check("irq", 32'(irq), 32'(exp_irq));
        end
    end

    // All bus tasks are entered on a falling edge and return on the next one.
    task automatic bus(input logic rd, input logic wr, input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_read      = rd;
        avs_write     = wr;
        @(negedge clk);
        avs_read  = 1'b0;
        avs_write = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus(1'b0, 1'b1, a, d);
    endtask

    task automatic rd(input logic [1:0] a);
        bus(1'b1, 1'b0, a, 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic measure(input int ch, output int n);
        logic s;
        s = led_out[ch];
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (led_out[ch] == s && n < 64);
    endtask

    task automatic random_ops(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            int op;
            logic [1:0] a;
            logic [31:0] d;
            op = int'($urandom_range(0, 9));
            a  = 2'($urandom_range(0, 3));
            case (a)
                2'd0:    d = 32'($urandom_range(0, 7));
                2'd3:    d = $urandom;
                default: d = 32'($urandom_range(0, 6));
            endcase
            bus((op <= 3) || (op == 9), (op >= 4 && op <= 7) || (op == 9), a, d);
        end
    endtask

    int n;

    initial begin
        reset_n       = 1'b0;
        avs_address   = '0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);

        // Reset state reads back through the scoreboard.
        rd(2'd3);
        rd(2'd1);
        rd(2'd0);
        idle(1);

        // Period 4 on channel 0: first rise 4 clocks after enable, then every 4.
        wr(2'd1, 32'd4);
        wr(2'd0, 32'd1);
        measure(0, n);
        check("t2_first_rise", 32'(n), 32'd4);
        measure(0, n);
        check("t2_half_period", 32'(n), 32'd4);
        idle(12);
        rd(2'd3);
        idle(2);

        // Period 0 on channel 1 toggles every clock; disable forces it low.
        wr(2'd2, 32'd0);
        wr(2'd0, 32'd2);
        measure(1, n);
        check("t3_first_rise", 32'(n), 32'd1);
        measure(1, n);
        check("t3_every_clock", 32'(n), 32'd1);
        wr(2'd0, 32'd0);
        idle(2);

        // Period write landing on the terminal count suppresses that toggle.
        wr(2'd1, 32'd10);
        wr(2'd0, 32'd1);
        idle(9);
        wr(2'd1, 32'd3);
        measure(0, n);
        check("t4_after_rewrite", 32'(n), 32'd3);
        rd(2'd3);
        idle(2);

        // Interrupt path with CTRL=5, period 2, and W1C clears.
        wr(2'd1, 32'd2);
        wr(2'd0, 32'd5);
        idle(6);
        bus(1'b1, 1'b1, 2'd3, 32'd4);
        idle(3);
        wr(2'd3, 32'd4);
        idle(4);
        bus(1'b1, 1'b1, 2'd0, 32'd7);
        idle(2);

        random_ops(600);

        // Reset mid-blink: outputs clear at once, registers return to reset values.
        wr(2'd1, 32'd3);
        wr(2'd0, 32'd3);
        idle(5);
        #2 reset_n = 1'b0;
        #1;
        check("rst_led_out", 32'(led_out), 32'd0);
        check("rst_readdata", avs_readdata, 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        rd(2'd1);
        rd(2'd0);
        rd(2'd3);
        idle(3);

        random_ops(300);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
